// File: rtl/lock_key_tx.sv
// Serial unlock-code transmitter: guard bits then the code MSB-first, one bit per BIT_CYCLES clocks.
// Define LOCK_KEY_TX_RETRY_EN to watch unlock_in after each attempt and retransmit on timeout.
module lock_key_tx #(
  parameter int CODE_W     = 4,
  parameter int BIT_CYCLES = 1,
  parameter int GUARD_BITS = 2,
  parameter int TIMEOUT    = 8,
  parameter int MAX_RETRY  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_valid,
  output logic              code_ready,
  output logic              data,
  output logic              busy,
  output logic              done,
  input  logic              unlock_in,
  output logic              fail
);

  localparam int CW = $clog2(BIT_CYCLES + 1);
  localparam int NB = (GUARD_BITS > CODE_W) ? GUARD_BITS : CODE_W;
  localparam int BW = $clog2(NB + 1);
  localparam logic [CW-1:0] CYC_LAST   = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] GUARD_LAST = BW'(GUARD_BITS - 1);
  localparam logic [BW-1:0] CODE_LAST  = BW'(CODE_W - 1);

`ifdef LOCK_KEY_TX_RETRY_EN
  typedef enum logic [1:0] {S_IDLE, S_GUARD, S_SEND, S_CHECK} state_t;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  logic [CODE_W-1:0] code_reg;
  logic [TW-1:0]     tmo_reg;
  logic [RW-1:0]     retry_reg;
  logic              fail_reg;
`else
  typedef enum logic [1:0] {S_IDLE, S_GUARD, S_SEND} state_t;
`endif

  state_t            state_reg;
  logic [CODE_W-1:0] shift_reg;
  logic [CODE_W-1:0] shift_next;
  logic [CW-1:0]     cyc_reg;
  logic [BW-1:0]     bit_reg;
  logic              data_reg;
  logic              done_reg;
  logic              bit_tick;

  assign shift_next[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < CODE_W; gi++) begin : g_shift
      assign shift_next[gi] = shift_reg[gi-1];
    end
  endgenerate

  assign bit_tick   = (cyc_reg == CYC_LAST);
  assign code_ready = (state_reg == S_IDLE) && !reset;
  assign busy       = (state_reg != S_IDLE);
  assign data       = data_reg;
  assign done       = done_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      shift_reg <= '0;
      cyc_reg   <= '0;
      bit_reg   <= '0;
      data_reg  <= 1'b1;
      done_reg  <= 1'b0;
`ifdef LOCK_KEY_TX_RETRY_EN
      code_reg  <= '0;
      tmo_reg   <= '0;
      retry_reg <= '0;
      fail_reg  <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
`ifdef LOCK_KEY_TX_RETRY_EN
      fail_reg <= 1'b0;
`endif
      case (state_reg)
        S_IDLE: begin
          data_reg <= 1'b1;
          if (code_valid) begin
            shift_reg <= code_in;
            cyc_reg   <= '0;
            bit_reg   <= '0;
`ifdef LOCK_KEY_TX_RETRY_EN
            code_reg  <= code_in;
            retry_reg <= '0;
`endif
            if (GUARD_BITS == 0) begin
              state_reg <= S_SEND;
              data_reg  <= code_in[CODE_W-1];
            end else begin
              state_reg <= S_GUARD;
            end
          end
        end
        S_GUARD: begin
          if (bit_tick) begin
            cyc_reg <= '0;
            if (bit_reg == GUARD_LAST) begin
              bit_reg   <= '0;
              state_reg <= S_SEND;
              data_reg  <= shift_reg[CODE_W-1];
            end else begin
              bit_reg <= bit_reg + 1'b1;
            end
          end else begin
            cyc_reg <= cyc_reg + 1'b1;
          end
        end
        S_SEND: begin
          if (bit_tick) begin
            cyc_reg   <= '0;
            shift_reg <= shift_next;
            if (bit_reg == CODE_LAST) begin
              bit_reg  <= '0;
              data_reg <= 1'b1;
`ifdef LOCK_KEY_TX_RETRY_EN
              state_reg <= S_CHECK;
              tmo_reg   <= '0;
`else
              state_reg <= S_IDLE;
              done_reg  <= 1'b1;
`endif
            end else begin
              bit_reg  <= bit_reg + 1'b1;
              data_reg <= shift_next[CODE_W-1];
            end
          end else begin
            cyc_reg <= cyc_reg + 1'b1;
          end
        end
`ifdef LOCK_KEY_TX_RETRY_EN
        S_CHECK: begin
          if (unlock_in) begin
            state_reg <= S_IDLE;
            done_reg  <= 1'b1;
          end else if (tmo_reg == TMO_LAST) begin
            tmo_reg <= '0;
            if (retry_reg < RETRY_MAX) begin
              // Resend from the latched copy; the shift register was consumed.
              retry_reg <= retry_reg + 1'b1;
              shift_reg <= code_reg;
              cyc_reg   <= '0;
              bit_reg   <= '0;
              if (GUARD_BITS == 0) begin
                state_reg <= S_SEND;
                data_reg  <= code_reg[CODE_W-1];
              end else begin
                state_reg <= S_GUARD;
              end
            end else begin
              state_reg <= S_IDLE;
              fail_reg  <= 1'b1;
            end
          end else begin
            tmo_reg <= tmo_reg + 1'b1;
          end
        end
`endif
        default: state_reg <= S_IDLE;
      endcase
    end
  end

`ifdef LOCK_KEY_TX_RETRY_EN
  assign fail = fail_reg;
`else
  // Retry inputs and parameters have no function in this build.
  logic unused_cfg;
  assign unused_cfg = unlock_in | (TIMEOUT < 0) | (MAX_RETRY < 0);
  assign fail = 1'b0;
`endif

endmodule

// File: tb/tb_lock_key_tx.sv
// Randomized and directed bench for lock_key_tx; a waveform-queue model predicts every output each cycle.
module tb_lock_key_tx;
  localparam int W = 4, B = 1, G = 2, TMO = 8, MR = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] code_in = '0;
  logic         code_valid = 1'b0;
  logic         unlock_in = 1'b0;
  logic         code_ready, data, busy, done, fail;

  always #5 clk = ~clk;

  lock_key_tx #(.CODE_W(W), .BIT_CYCLES(B), .GUARD_BITS(G), .TIMEOUT(TMO), .MAX_RETRY(MR)) dut (
    .clk(clk), .reset(reset), .code_in(code_in), .code_valid(code_valid),
    .code_ready(code_ready), .data(data), .busy(busy), .done(done),
    .unlock_in(unlock_in), .fail(fail)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: on each (re)transmission the expected line waveform is queued
  // as G*B ones followed by each code bit repeated B times.
  logic    q[$];
  bit      m_busy = 0, m_chk = 0;
  int      m_cnt = 0, m_retries = 0, cyc = 0;
  logic [W-1:0] m_code = '0;
  logic    exp_data = 1'b1, exp_done = 1'b0, exp_fail = 1'b0;
  bit      mon_en = 0;

  task automatic load_wave();
    q.delete();
    repeat (G * B) q.push_back(1'b1);
    for (int i = W - 1; i >= 0; i--) repeat (B) q.push_back(m_code[i]);
  endtask

  always @(posedge clk) begin
    cyc++;
    exp_done = 1'b0;
    exp_fail = 1'b0;
    if (reset) begin
      m_busy = 0; m_chk = 0; q.delete(); exp_data = 1'b1;
    end else if (!m_busy) begin
      exp_data = 1'b1;
      if (code_valid) begin
        m_code = code_in; m_retries = 0; m_busy = 1;
        load_wave();
        exp_data = q.pop_front();
        $display("tx cycle %0d: accept code %b", cyc, code_in);
      end
    end else if (q.size() > 0) begin
      exp_data = q.pop_front();
    end else if (!m_chk) begin
      exp_data = 1'b1;
`ifdef LOCK_KEY_TX_RETRY_EN
      m_chk = 1; m_cnt = 0;
`else
      m_busy = 0; exp_done = 1'b1;
`endif
    end else begin
      exp_data = 1'b1;
      if (unlock_in) begin
        m_chk = 0; m_busy = 0; exp_done = 1'b1;
      end else begin
        m_cnt++;
        if (m_cnt == TMO) begin
          m_chk = 0;
          if (m_retries < MR) begin
            m_retries++;
            load_wave();
            exp_data = q.pop_front();
          end else begin
            m_busy = 0; exp_fail = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("data", 32'(data), 32'(exp_data));
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(exp_done));
      check("fail", 32'(fail), 32'(exp_fail));
      check("code_ready", 32'(code_ready), 32'(!reset && !m_busy));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a code and return in the cycle right after the accept edge.
  task automatic send_accept(input logic [W-1:0] c);
    int n;
    code_in = c;
    code_valid = 1'b1;
    n = 0;
    while (!code_ready && n < 300) begin
      tick();
      n++;
    end
    check("accept_wait", 32'(code_ready), 32'd1);
    tick();
    code_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    check("idle_wait", 32'(busy), 32'd0);
    tick();
  endtask

  initial begin
    logic [5:0] pat;
    int n, zeros, dones, fails;

    repeat (3) @(posedge clk);
    #1;
    mon_en = 1;
    tick();
    check("reset_data", 32'(data), 32'd1);
    check("reset_ready", 32'(code_ready), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_ready", 32'(code_ready), 32'd1);

    // Basic stream of 4'b0100: 1,1,0,1,0,0 then idle.
    send_accept(4'b0100);
    for (int i = 0; i < 6; i++) begin
      pat[5-i] = data;
      check("stream_busy", 32'(busy), 32'd1);
      tick();
    end
    check("stream_pattern", 32'(pat), 32'b110100);
    check("stream_end_data", 32'(data), 32'd1);
`ifdef LOCK_KEY_TX_RETRY_EN
    check("stream_end_check", 32'(busy), 32'd1);
    unlock_in = 1'b1;
    tick();
    unlock_in = 1'b0;
    check("stream_unlock_done", 32'(done), 32'd1);
`else
    check("stream_done", 32'(done), 32'd1);
    check("stream_ready", 32'(code_ready), 32'd1);
`endif
    wait_idle();

    // Back-to-back: valid held high, second code accepted right after the first completes.
    code_in = 4'b1010;
    code_valid = 1'b1;
    unlock_in = 1'b1;
    n = 0;
    while (!code_ready && n < 50) begin tick(); n++; end
    tick();
    code_in = 4'b0011;
    n = 0;
    while (!code_ready && n < 50) begin tick(); n++; end
`ifdef LOCK_KEY_TX_RETRY_EN
    check("b2b_ready_cycle", 32'(n), 32'd7);
`else
    check("b2b_ready_cycle", 32'(n), 32'd6);
`endif
    tick();
    code_valid = 1'b0;
    unlock_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pat[5-i] = data;
      tick();
    end
    check("b2b_pattern", 32'(pat), 32'b110011);
    unlock_in = 1'b1;
    wait_idle();
    unlock_in = 1'b0;

    // Reset in the middle of a transfer aborts it silently.
    send_accept(4'b0100);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("abort_data", 32'(data), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(code_ready), 32'd0);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin tick(); dones += int'(done); end
    check("abort_no_done", 32'(dones), 32'd0);
    check("abort_ready_after", 32'(code_ready), 32'd1);
    unlock_in = 1'b1;
    send_accept(4'b0110);
    wait_idle();
    unlock_in = 1'b0;

`ifdef LOCK_KEY_TX_RETRY_EN
    // No unlock: four attempts, 8 check cycles each, then one fail pulse.
    send_accept(4'b0100);
    n = 0; zeros = 0; dones = 0;
    while (!fail && n < 200) begin
      zeros += int'(!data);
      dones += int'(done);
      tick();
      n++;
    end
    check("retry_fail_cycle", 32'(n), 32'd56);
    check("retry_zero_bits", 32'(zeros), 32'd12);
    check("retry_no_done", 32'(dones), 32'd0);
    tick();
    check("retry_idle", 32'(busy), 32'd0);
    check("retry_fail_pulse", 32'(fail), 32'd0);

    // Unlock on the second check edge of the first attempt.
    send_accept(4'b0100);
    repeat (7) tick();
    unlock_in = 1'b1;
    tick();
    unlock_in = 1'b0;
    check("unlock_done", 32'(done), 32'd1);
    fails = 0; n = 0;
    for (int i = 0; i < 30; i++) begin tick(); fails += int'(fail); n += int'(busy); end
    check("unlock_no_fail", 32'(fails), 32'd0);
    check("unlock_no_resend", 32'(n), 32'd0);
`endif

    // Random traffic, occasional resets and unlock pulses.
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      code_valid = ($urandom_range(0, 2) != 0);
      code_in = W'($urandom);
      unlock_in = ($urandom_range(0, 9) == 0);
      tick();
    end
    reset = 1'b0;
    code_valid = 1'b0;
    unlock_in = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lock_key_tx.md
# lock_key_tx

Serial unlock-code transmitter: the sending end of the serial digital-lock link. It accepts a `CODE_W`-bit code over a valid/ready handshake and shifts it out MSB-first on a single line, one bit per `BIT_CYCLES` clocks. The code is preceded by `GUARD_BITS` idle-high bits so a sequence-detecting lock restarts from its initial state. It sits between the key/test controller and the lock's `data` input; optionally it watches the lock's unlock output and retries.

## Interface
- `CODE_W`, 4: code length in bits, ≥1.
- `BIT_CYCLES`, 1: clocks each bit is held, ≥1.
- `GUARD_BITS`, 2: idle-high bits sent before the code, ≥0.
- `TIMEOUT`, 8: clocks to wait for unlock after the last bit (retry build only), ≥1.
- `MAX_RETRY`, 3: retransmissions after the first attempt (retry build only), ≥0.
- `clk` in 1: clock, rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `code_in` in CODE_W: code to send, MSB sent first.
- `code_valid` in 1: `code_in` valid.
- `code_ready` out 1: block can accept; accepted on an edge with `code_valid && code_ready`.
- `data` out 1: serial line, registered, idle level 1.
- `busy` out 1: transmission/check in progress.
- `done` out 1: one-cycle pulse at successful completion.
- `unlock_in` in 1: lock's unlock indication (retry build only; ignored otherwise).
- `fail` out 1: one-cycle pulse when retries are exhausted (tied 0 without retry).

## Operation
- States: IDLE, GUARD, SEND, CHECK (CHECK exists only in the retry build).
- IDLE: `code_ready`=1, `data`=1, `busy`=0. On accept, the code is latched into the shift register and the block goes to GUARD, or straight to SEND when `GUARD_BITS`=0. The bit and cycle counters clear and the retry counter clears.
- GUARD: `data`=1 for `GUARD_BITS*BIT_CYCLES` clocks, then SEND.
- SEND: `data` = current MSB, held `BIT_CYCLES` clocks, then shift left. After `CODE_W` bits:
  - Without retry: go to IDLE, `done`=1, `data`=1.
  - With retry: go to CHECK, `data`=1.
- CHECK: on any edge with `unlock_in`=1, go to IDLE with `done`=1. After `TIMEOUT` edges without it:
  - If retry count < `MAX_RETRY`: increment it and go to GUARD, resending the latched code (the original `code_in` is not resampled).
  - Otherwise: go to IDLE with `fail`=1.
- `busy`=1 in every state except IDLE. `code_ready` = (state==IDLE).
- `code_valid` while busy is ignored; no queuing.
- `done` and `fail` are never high together. Neither pulses on reset.
- Reset mid-operation: the transfer is aborted silently and the latched code is discarded.

## Timing
- Reset values: `data`=1, `busy`=0, `done`=0, `fail`=0, `code_ready`=0 while `reset` is high; the state is IDLE.
- Let the accept edge be E0, G=`GUARD_BITS`, W=`CODE_W`, B=`BIT_CYCLES`.
- Guard bits are driven from edge E0 to E0+G·B.
- Code bit i (i=0 is the MSB) is driven from edge E0+(G+i)·B to E0+(G+i+1)·B.
- At edge E0+(G+W)·B, `data` returns to 1.
  - Without retry: `done`=1 and `code_ready`=1 in that same cycle. A new code can be accepted on the next edge, which is also the edge where `done` drops.
  - With retry: CHECK starts at that edge. `unlock_in` is sampled on the following edges.
- Each retry restarts the guard at the edge that leaves CHECK, with the same G/W/B timing.

## Configuration
- `LOCK_KEY_TX_RETRY_EN` defined: CHECK state, `unlock_in` monitoring, `TIMEOUT`/`MAX_RETRY` counters and `fail` are all active.
- Not defined: no CHECK state. `done` pulses immediately after the last bit, `unlock_in` is unused and `fail` is constant 0.

## Test plan
- W=4, B=1, G=2, `code_in`=4'b0100 accepted at edge 0 -> `data` over cycles 0–5 = 1,1,0,1,0,0. `data`=1, `done`=1, `code_ready`=1 in cycle 6; `busy`=1 in cycles 0–5.
- Same code with B=3 -> each bit is held 3 cycles, the first 0 starts at edge 6, and `done` pulses at edge 18.
- `code_valid` held high with 4'b1010, then 4'b0011 (no retry) -> the second code is accepted on the edge after the first `done` cycle. The second stream is guard 1,1 then 0,0,1,1, with no extra idle cycles.
- `reset` high at edge 3 of a 4'b0100 transfer -> from edge 3, `data`=1, `busy`=0 and `code_ready`=0. No `done` follows; after release, `code_ready`=1 and a new accept works normally.
- Retry build, TIMEOUT=8, MAX_RETRY=3, `unlock_in`=0 -> exactly 4 full transmissions, each separated by 8 CHECK cycles. One `fail` pulse, `done` never asserts, and the block returns to IDLE.
- Retry build, `unlock_in` pulsed high on the 2nd CHECK edge of the first attempt -> `done` pulses, no retransmission, `fail` stays 0.
